// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane enable helper.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane enables; a half-word picks its lanes from A[1] only.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            HSIZE_BYTE: byte_enables = 4'b0001 << lsb;
            HSIZE_HALF: byte_enables = lsb[1] ? 4'b1100 : 4'b0011;
            default:    byte_enables = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahbl_bytelane_ram.sv
// Word-organised SRAM with per-byte write enables and a registered read port.
module ahbl_bytelane_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    // Read-before-write on a same-address collision; the top forwards around it.
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b])
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite responder serving a byte-writable SRAM with wait states, two-cycle ERROR
// and a one-entry write buffer whose contents are forwarded to colliding reads.
module ahbl_sram_responder
    import ahbl_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 0,
    parameter bit ERR_UNALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

    state_t            state;
    logic [2:0]        wait_cnt;
    logic              hready_q;
    logic [1:0]        hresp_q;

    logic [MEM_AW-1:0] word_addr;
    logic              accept;
    logic              xfer_err;
    logic              accept_ok;
    logic              capture;

    logic              dp_wr;
    logic [MEM_AW-1:0] dp_addr;
    logic [3:0]        dp_be;

    logic              wb_valid;
    logic [MEM_AW-1:0] wb_addr;
    logic [3:0]        wb_be;
    logic [31:0]       wb_data;

    logic              rd_zero;
    logic [3:0]        fwd_be;
    logic [31:0]       fwd_data;
    logic [3:0]        fwd_be_next;
    logic [31:0]       fwd_data_next;
    logic [31:0]       ram_q;

    logic              unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign word_addr = HADDR[MEM_AW+1:2];
    assign accept    = HSEL & HREADY & HTRANS[1] & hready_q;
    assign xfer_err  = (HSIZE > HSIZE_WORD)
                     | ((HADDR >> (MEM_AW + 2)) != 32'd0)
                     | (ERR_UNALIGN & (((HSIZE == HSIZE_HALF) & HADDR[0])
                                     | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))));
    assign accept_ok = accept & ~xfer_err;
    assign capture   = dp_wr & hready_q;

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;

    // Data-phase sequencing; READY/RESP are registered alongside the state.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state    <= ST_DONE;
                        hready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    if (accept & xfer_err) begin
                        state    <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else if (accept_ok && (WAIT_STATES > 0)) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_OKAY;
                    end else begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Newest write wins: data captured this edge overrides the buffer being committed.
    always_comb begin
        fwd_be_next   = 4'b0000;
        fwd_data_next = wb_data;
        for (int b = 0; b < 4; b++) begin
            if (wb_valid && (wb_addr == word_addr) && wb_be[b])
                fwd_be_next[b] = 1'b1;
            if (capture && (dp_addr == word_addr) && dp_be[b]) begin
                fwd_be_next[b]           = 1'b1;
                fwd_data_next[8*b +: 8]  = HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_wr    <= 1'b0;
            dp_addr  <= '0;
            dp_be    <= 4'b0000;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_be    <= 4'b0000;
            wb_data  <= 32'd0;
            rd_zero  <= 1'b1;
            fwd_be   <= 4'b0000;
            fwd_data <= 32'd0;
        end else begin
            wb_valid <= capture;
            if (capture) begin
                wb_addr <= dp_addr;
                wb_be   <= dp_be;
                wb_data <= HWDATA;
            end
            if (accept) begin
                dp_wr   <= accept_ok & HWRITE;
                dp_addr <= word_addr;
                dp_be   <= byte_enables(HSIZE, HADDR[1:0]);
            end else if (capture) begin
                dp_wr <= 1'b0;
            end
            if (accept & ~HWRITE) begin
                rd_zero  <= xfer_err;
                fwd_be   <= fwd_be_next;
                fwd_data <= fwd_data_next;
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (!rd_zero) begin
            for (int b = 0; b < 4; b++)
                HRDATA[8*b +: 8] = fwd_be[b] ? fwd_data[8*b +: 8] : ram_q[8*b +: 8];
        end
    end

    ahbl_bytelane_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk     (HCLK),
        .rd_en   (accept_ok & ~HWRITE),
        .rd_addr (word_addr),
        .rd_data (ram_q),
        .wr_be   (wb_valid ? wb_be : 4'b0000),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed scoreboard bench: a zero-wait and a three-wait responder share one pipelined master.
module tb_ahbl_sram_responder;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } stim_t;

    typedef struct {
        bit          is_xfer;
        bit          write;
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic [2:0]  HBURST = 3'b000;
    logic [3:0]  HPROT = 4'b0011;
    logic        HWRITE = 1'b0;
    logic        HMASTLOCK = 1'b0;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY;
    logic        force_low = 1'b0;
    logic        sel = 1'b0;

    logic        ready0, ready3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic        hready_mux;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int vectors = 0;
    int fails   = 0;

    stim_t       stim_q[$];
    exp_t        sb_q[$];
    logic [31:0] model_mem [2][1024];

    always #5 HCLK = ~HCLK;

    assign hready_mux = sel ? ready3 : ready0;
    assign HREADY     = force_low ? 1'b0 : hready_mux;
    assign hresp      = sel ? resp3 : resp0;
    assign hrdata     = sel ? rdata3 : rdata0;

    ahbl_sram_responder #(.MEM_AW(10), .WAIT_STATES(0), .ERR_UNALIGN(1'b1)) u_dut0 (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL & ~sel), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahbl_sram_responder #(.MEM_AW(10), .WAIT_STATES(3), .ERR_UNALIGN(1'b1)) u_dut3 (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL & sel), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                                  input logic [2:0] size, input logic [31:0] wdata);
        stim_t s;
        s.trans = trans; s.write = write; s.addr = addr; s.size = size; s.wdata = wdata;
        stim_q.push_back(s);
    endtask

    function automatic bit exp_error(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2)                        return 1'b1;
        if (a[31:12] != 20'd0)               return 1'b1;
        if (s == 3'd1 && a[0])               return 1'b1;
        if (s == 3'd2 && a[1:0] != 2'b00)    return 1'b1;
        return 1'b0;
    endfunction

    // Reference memory: committed in program order at address-phase acceptance.
    task automatic model_accept(input stim_t s);
        exp_t e;
        int   n;
        int   first;
        e.is_xfer = s.trans[1];
        e.write   = s.write;
        e.err     = e.is_xfer && exp_error(s.addr, s.size);
        e.rdata   = 32'd0;
        e.waits   = !e.is_xfer ? 0 : (e.err ? 1 : (sel ? 3 : 0));
        if (e.is_xfer && !e.err) begin
            if (s.write) begin
                n     = 1 << s.size;
                first = int'(s.addr[1:0]);
                for (int k = 0; k < n; k++)
                    model_mem[sel][s.addr[11:2]][8*(first+k) +: 8] = s.wdata[8*(first+k) +: 8];
            end else begin
                e.rdata = model_mem[sel][s.addr[11:2]];
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic drive_addr(input bit valid, input stim_t s);
        HSEL   = valid;
        HTRANS = valid ? s.trans : 2'b00;
        HADDR  = s.addr;
        HWRITE = s.write;
        HSIZE  = s.size;
    endtask

    // Pipelined master: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
    task automatic run_bus(input int budget);
        stim_t ap;
        exp_t  e;
        bit    ap_valid = 1'b0;
        bit    dp_valid = 1'b0;
        bit    accepted;
        int    waits = 0;
        int    cycles = 0;
        ap = '{default: '0};
        if (stim_q.size() > 0) begin
            ap = stim_q.pop_front();
            ap_valid = 1'b1;
        end
        drive_addr(ap_valid, ap);
        while ((ap_valid || dp_valid) && cycles < budget) begin
            @(negedge HCLK);
            if (dp_valid) begin
                e = sb_q[0];
                if (!HREADY) begin
                    waits++;
                    check_output("resp_low", {30'd0, hresp}, e.err ? 32'd1 : 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_output("resp", {30'd0, hresp}, e.err ? 32'd1 : 32'd0);
                    check_output("wait_cycles", 32'(waits), 32'(e.waits));
                    if (e.is_xfer && !e.write)
                        check_output("rdata", hrdata, e.rdata);
                    dp_valid = 1'b0;
                end
            end
            accepted = ap_valid && HREADY;
            if (accepted)
                model_accept(ap);
            @(posedge HCLK);
            #1;
            if (accepted) begin
                dp_valid = 1'b1;
                waits    = 0;
                HWDATA   = ap.wdata;
                ap_valid = 1'b0;
                if (stim_q.size() > 0) begin
                    ap = stim_q.pop_front();
                    ap_valid = 1'b1;
                end
            end
            drive_addr(ap_valid, ap);
            cycles++;
        end
        check_output("bus_timeout", {31'd0, (ap_valid || dp_valid)}, 32'd0);
        stim_q.delete();
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values on both responders.
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_output("rst_ready0", {31'd0, ready0}, 32'd1);
        check_output("rst_resp0",  {30'd0, resp0},  32'd0);
        check_output("rst_rdata0", rdata0,          32'd0);
        check_output("rst_ready3", {31'd0, ready3}, 32'd1);
        check_output("rst_rdata3", rdata3,          32'd0);
        HRESETN = 1'b1;
        @(posedge HCLK);
        #1;

        // Zero-wait traffic, back-to-back, including read-after-write forwarding.
        sel = 1'b0;
        apply_stimulus(2'b10, 1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b1, 32'h0000_0013, 3'd0, 32'h5500_0000);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b1, 32'h0000_0014, 3'd2, 32'h1122_3344);
        apply_stimulus(2'b11, 1'b1, 32'h0000_0016, 3'd1, 32'hCAFE_0000);
        apply_stimulus(2'b10, 1'b1, 32'h0000_0000, 3'd2, 32'hA5A5_0001);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0014, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0000, 3'd2, 32'h0);
        run_bus(60);

        // Error responses, idle/busy slots and a byte read returning the whole word.
        apply_stimulus(2'b10, 1'b0, 32'h0000_0002, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b1, 32'h0001_0000, 3'd2, 32'hFFFF_FFFF);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0000, 3'd2, 32'h0);
        apply_stimulus(2'b00, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        apply_stimulus(2'b01, 1'b1, 32'h0000_0010, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0008, 3'd3, 32'h0);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0001, 3'd1, 32'h0);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0013, 3'd0, 32'h0);
        run_bus(60);

        // NONSEQ write while HREADY is low must be ignored.
        force_low = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0000; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        force_low = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hBAD0_BAD0;
        @(negedge HCLK);
        check_output("hready_low_ready", {31'd0, ready0}, 32'd1);
        check_output("hready_low_resp",  {30'd0, resp0},  32'd0);
        @(posedge HCLK);
        #1;
        apply_stimulus(2'b10, 1'b0, 32'h0000_0000, 3'd2, 32'h0);
        run_bus(20);

        // Three wait states; errors stay at two cycles without extra waits.
        sel = 1'b1;
        apply_stimulus(2'b10, 1'b1, 32'h0000_0040, 3'd2, 32'h0BAD_F00D);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0040, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0042, 3'd2, 32'h0);
        apply_stimulus(2'b10, 1'b1, 32'h0000_0041, 3'd0, 32'h0000_7700);
        apply_stimulus(2'b10, 1'b0, 32'h0000_0040, 3'd2, 32'h0);
        run_bus(80);

        // Reset in the middle of a waited write: outputs drop to reset values at once.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0040; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFFF;
        @(negedge HCLK);
        check_output("abort_in_wait", {31'd0, ready3}, 32'd0);
        #1;
        HRESETN = 1'b0;
        #1;
        check_output("abort_ready", {31'd0, ready3}, 32'd1);
        check_output("abort_resp",  {30'd0, resp3},  32'd0);
        check_output("abort_rdata", rdata3,          32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETN = 1'b1;
        @(posedge HCLK);
        #1;
        apply_stimulus(2'b10, 1'b0, 32'h0000_0040, 3'd2, 32'h0);
        run_bus(30);
        sel = 1'b0;
        apply_stimulus(2'b10, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        run_bus(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
